// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM encoding and default operand width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Counter must reach WIDTH without wrapping.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/full_adder_behav.sv
// Single-bit full adder used as the one arithmetic slice of the serial adder.
module full_adder_behav (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per clock through one
// full-adder slice, controlled by an IDLE/RUN/DONE state machine.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [1:0]       state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_r;
  logic             carry_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;

  logic             fa_sum_s;
  logic             fa_cout_s;
  logic [WIDTH-1:0] res_next_s;
  logic             last_bit_s;

  full_adder_behav u_slice (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .cin  (carry_r),
    .sum  (fa_sum_s),
    .cout (fa_cout_s)
  );

  // Slice sum enters from the MSB side; the shift form also covers WIDTH=1.
  assign res_next_s = WIDTH'({fa_sum_s, res_r} >> 1'b1);
  assign last_bit_s = (cnt_r == CNT_W'(WIDTH - 1));

  // FSM, operand/result shift registers, carry, counter and held outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      res_r   <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            carry_r <= cin;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh_r  <= a_sh_r >> 1'b1;
          b_sh_r  <= b_sh_r >> 1'b1;
          res_r   <= res_next_s;
          carry_r <= fa_cout_s;
          cnt_r   <= cnt_r + CNT_W'(1);
          if (last_bit_s) begin
            sum_r   <= res_next_s;
            cout_r  <= fa_cout_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH 8, 4 and 1: directed vectors
// push expected results and done cycles; a negedge monitor pops and compares.
module tb_serial_adder_ctrl;

  typedef struct {
    logic [7:0] s;
    logic       c;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [2:0]      start_v, cin_v;
  logic [2:0][7:0] a_v, b_v;
  logic [2:0]      busy_v, done_v, cout_v;
  logic [2:0][7:0] sum_v;
  logic [2:0][7:0] last_s;
  logic [2:0]      last_c;

  logic       busy0, busy1, busy2, done0, done1, done2, cout0, cout1, cout2;
  logic [7:0] sum0;
  logic [3:0] sum1;
  logic [0:0] sum2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]),
    .busy(busy0), .done(done0), .sum(sum0), .cout(cout0));

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1][3:0]), .b(b_v[1][3:0]), .cin(cin_v[1]),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2][0:0]), .b(b_v[2][0:0]), .cin(cin_v[2]),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2));

  assign busy_v = {busy2, busy1, busy0};
  assign done_v = {done2, done1, done0};
  assign cout_v = {cout2, cout1, cout0};
  assign sum_v  = {{7'b0, sum2}, {4'b0, sum1}, sum0};

  function automatic int wv(input int i);
    case (i)
      0:       return 8;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input logic [7:0] s, input logic c, input int at);
    exp_t e;
    e.s = s; e.c = c; e.cyc = at;
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic mon(input int i);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (rst) begin
      last_s[i] = 8'h00;
      last_c[i] = 1'b0;
    end else if (done_v[i]) begin
      case (i)
        0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      endcase
      if (have) begin
        chk($sformatf("sum_w%0d", wv(i)), {24'd0, sum_v[i]}, {24'd0, e.s});
        chk($sformatf("cout_w%0d", wv(i)), {31'd0, cout_v[i]}, {31'd0, e.c});
        chk($sformatf("done_cycle_w%0d", wv(i)), cyc, e.cyc);
      end else begin
        chk($sformatf("unexpected_done_w%0d", wv(i)), 32'd1, 32'd0);
      end
      last_s[i] = sum_v[i];
      last_c[i] = cout_v[i];
    end else begin
      chk($sformatf("sum_hold_w%0d", wv(i)), {23'd0, sum_v[i], cout_v[i]}, {23'd0, last_s[i], last_c[i]});
    end
  endtask

  // Monitor: compares every done against the scoreboard and checks hold between dones
  always @(negedge clk) begin
    mon(0);
    mon(1);
    mon(2);
  end

  // One operation: start for one cycle, scramble inputs after acceptance, check busy window
  task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] es, input logic ec, input bit nowait);
    int w;
    w = wv(i);
    if (!nowait) @(negedge clk);
    a_v[i] = a; b_v[i] = b; cin_v[i] = c; start_v[i] = 1'b1;
    push(i, es, ec, cyc + 1 + w);
    for (int k = 1; k <= w + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start_v[i] = 1'b0;
        a_v[i] = ~a; b_v[i] = ~b; cin_v[i] = ~c;
      end
      chk($sformatf("busy_w%0d_k%0d", w, k), {31'd0, busy_v[i]}, {31'd0, (k <= w)});
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 200; t++) begin
      if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_pending", q0.size() + q1.size() + q2.size(), 32'd0);
  endtask

  initial begin
    int c0;
    logic [4:0] r;
    rst = 1'b1;
    start_v = 3'b0; cin_v = 3'b0; a_v = '0; b_v = '0;
    last_s = '0; last_c = 3'b0;
    #1;
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_sum",  {24'd0, sum0}, 32'd0);
    chk("rst_cout", {31'd0, cout0}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    issue(0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    issue(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    issue(0, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
    issue(0, 8'h80, 8'h7F, 1'b0, 8'hFF, 1'b0, 1'b0);

    issue(2, 8'h01, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0);
    issue(2, 8'h00, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0);

    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        for (int cv = 0; cv < 2; cv++) begin
          r = 5'(av) + 5'(bv) + 5'(cv);
          issue(1, 8'(av), 8'(bv), 1'(cv), {4'b0, r[3:0]}, r[4], 1'b0);
        end
      end
    end

    // Start held high: second accept lands 10 edges later with the changed operands
    @(negedge clk);
    c0 = cyc;
    a_v[0] = 8'h12; b_v[0] = 8'h34; cin_v[0] = 1'b0; start_v[0] = 1'b1;
    push(0, 8'h46, 1'b0, c0 + 9);
    push(0, 8'hFE, 1'b1, c0 + 19);
    repeat (3) @(negedge clk);
    a_v[0] = 8'hFF; b_v[0] = 8'hFF;
    repeat (8) @(negedge clk);
    start_v[0] = 1'b0;
    wait_drain();

    // Asynchronous reset after E4 aborts the operation
    @(negedge clk);
    c0 = cyc;
    a_v[0] = 8'h55; b_v[0] = 8'h11; cin_v[0] = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_before_abort", {31'd0, busy0}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy0}, 32'd0);
    chk("abort_done", {31'd0, done0}, 32'd0);
    chk("abort_sum",  {24'd0, sum0}, 32'd0);
    chk("abort_cout", {31'd0, cout0}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    issue(0, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b1);
    wait_drain();
    repeat (12) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
